// File: rtl/neopixel_frame_ctrl.sv
// Double-buffered pixel store and frame scheduler feeding the neopixel serializer.
// Buffers swap only at a frame boundary; reads are brightness-scaled and bit-reordered.
module neopixel_frame_ctrl #(
    parameter int NUM_OF_PIXELS = 8,
    parameter int ADDR_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              fill_req,
    input  logic [23:0]       fill_data,
    input  logic              commit,
    output logic              commit_pending,
    output logic              busy,
    input  logic [7:0]        brightness,
    input  logic [ADDR_W-1:0] ram_rd_addr,
    output logic [23:0]       ram_rd_data,
    output logic              frame_done
);

    localparam int IDX_W = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [ADDR_W-1:0] NUM_A    = ADDR_W'(NUM_OF_PIXELS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_OF_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, FILL, PEND, COPY} state_t;

    state_t             state, next_state;
    logic [23:0]        mem0 [DEPTH];
    logic [23:0]        mem1 [DEPTH];
    logic               front_sel;
    logic               front_valid;
    logic               commit_latched;
    logic [IDX_W-1:0]   idx;
    logic [23:0]        fill_color;
    logic [ADDR_W-1:0]  prev_addr;
    logic               boundary;
    logic               we;
    logic [IDX_W-1:0]   widx;
    logic [23:0]        wdata;
    logic               start_fill;
    logic               swap;
    logic [23:0]        copy_word;
    logic [23:0]        rd_word;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [23:0] bitrev(input logic [23:0] v);
        logic [23:0] r;
        for (int i = 0; i < 24; i++) begin
            r[i] = v[23 - i];
        end
        return r;
    endfunction

    assign boundary  = (prev_addr != '0) && (ram_rd_addr == '0);
    assign copy_word = front_sel ? mem1[idx] : mem0[idx];
    assign rd_word   = front_sel ? mem1[ram_rd_addr[IDX_W-1:0]] : mem0[ram_rd_addr[IDX_W-1:0]];

    assign wr_ready       = (state == IDLE);
    assign busy           = (state != IDLE);
    assign commit_pending = (state == PEND) || ((state == FILL) && commit_latched);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The back buffer has a single write port shared by host writes, fill and copy.
    always_comb begin
        next_state = state;
        we         = 1'b0;
        widx       = idx;
        wdata      = fill_color;
        start_fill = 1'b0;
        swap       = 1'b0;
        case (state)
            IDLE: begin
                if (wr_valid && (wr_addr < NUM_A)) begin
                    we    = 1'b1;
                    widx  = wr_addr[IDX_W-1:0];
                    wdata = wr_data;
                end
                if (fill_req) begin
                    next_state = FILL;
                    start_fill = 1'b1;
                end else if (commit) begin
                    next_state = PEND;
                end
            end
            FILL: begin
                we = 1'b1;
                if (idx == LAST_IDX) begin
                    next_state = (commit_latched || commit) ? PEND : IDLE;
                end
            end
            PEND: begin
                if (boundary) begin
                    next_state = COPY;
                    swap       = 1'b1;
                end
            end
            COPY: begin
                we    = 1'b1;
                wdata = copy_word;
                if (idx == LAST_IDX) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel      <= 1'b0;
            front_valid    <= 1'b0;
            commit_latched <= 1'b0;
            idx            <= '0;
            fill_color     <= '0;
            prev_addr      <= '0;
            frame_done     <= 1'b0;
        end else begin
            prev_addr      <= ram_rd_addr;
            frame_done     <= boundary;
            commit_latched <= start_fill ? commit
                                         : ((state == FILL) && (commit_latched || commit));
            if (start_fill) begin
                fill_color <= fill_data;
            end
            if (start_fill || swap) begin
                idx <= '0;
            end else if ((state == FILL) || (state == COPY)) begin
                idx <= idx + IDX_W'(1);
            end
            if (swap) begin
                front_sel   <= ~front_sel;
                front_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            if (front_sel) begin
                mem0[widx] <= wdata;
            end else begin
                mem1[widx] <= wdata;
            end
        end
    end

    // Output stream order is G, R, B with each channel MSB-first starting at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rd_data <= '0;
        end else if (front_valid && (ram_rd_addr < NUM_A)) begin
            ram_rd_data <= bitrev({scale(rd_word[15:8], brightness),
                                   scale(rd_word[23:16], brightness),
                                   scale(rd_word[7:0], brightness)});
        end else begin
            ram_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Randomized bench for neopixel_frame_ctrl: stimulus pushes expectations into a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_neopixel_frame_ctrl;

    localparam int NPIX = 8;
    localparam int AW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic          fill_req = 1'b0;
    logic [23:0]   fill_data = '0;
    logic          commit = 1'b0;
    logic          commit_pending;
    logic          busy;
    logic [7:0]    brightness = 8'd255;
    logic [AW-1:0] ram_rd_addr = '0;
    logic [23:0]   ram_rd_data;
    logic          frame_done;

    neopixel_frame_ctrl #(.NUM_OF_PIXELS(NPIX), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .fill_req(fill_req), .fill_data(fill_data), .commit(commit),
        .commit_pending(commit_pending), .busy(busy), .brightness(brightness),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          due;
        int          sig;
        logic [23:0] exp;
    } chk_t;

    chk_t  exp_q[$];
    string name_q[$];

    // Reference model: whole-image arrays, swapped as pictures rather than buffers.
    logic [23:0] front_img [NPIX];
    logic [23:0] back_img  [NPIX];
    bit          model_fv = 1'b0;

    function automatic logic [23:0] model_read(input int a);
        logic [23:0] res;
        int ch[3];
        int s;
        res = '0;
        if (!model_fv || a >= NPIX) return res;
        ch[0] = int'(front_img[a][15:8]);
        ch[1] = int'(front_img[a][23:16]);
        ch[2] = int'(front_img[a][7:0]);
        for (int c = 0; c < 3; c++) begin
            s = (ch[c] * (int'(brightness) + 1)) / 256;
            for (int b = 0; b < 8; b++) begin
                res[c*8 + b] = ((s >> (7 - b)) & 1) != 0;
            end
        end
        return res;
    endfunction

    chk_t        mc;
    string       mn;
    logic [23:0] act;

    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due <= cyc) begin
                mc = exp_q[i];
                mn = name_q[i];
                exp_q.delete(i);
                name_q.delete(i);
                case (mc.sig)
                    0:       act = ram_rd_data;
                    1:       act = {23'd0, wr_ready};
                    2:       act = {23'd0, busy};
                    3:       act = {23'd0, commit_pending};
                    default: act = {23'd0, frame_done};
                endcase
                checks++;
                if (mc.due != cyc || act !== mc.exp) begin
                    failures++;
                    $display("[TB] FAIL %s cycle=%0d due=%0d got=%h expected=%h",
                             mn, cyc, mc.due, act, mc.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string n, input int sig, input int delay, input logic [23:0] e);
        chk_t c;
        c.due = cyc + delay;
        c.sig = sig;
        c.exp = e;
        exp_q.push_back(c);
        name_q.push_back(n);
    endtask

    task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [23:0] wd,
                                 input logic fr, input logic [23:0] fd, input logic cm);
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        fill_req  = fr;
        fill_data = fd;
        commit    = cm;
        tick();
        wr_valid  = 1'b0;
        fill_req  = 1'b0;
        commit    = 1'b0;
    endtask

    task automatic writePixel(input int a, input logic [23:0] d);
        checkOutput("wr_ready_idle", 1, 0, 24'd1);
        applyStimulus(1'b1, AW'(a), d, 1'b0, 24'd0, 1'b0);
        if (a < NPIX) back_img[a] = d;
    endtask

    task automatic doCommit();
        checkOutput("commit_pending_set", 3, 1, 24'd1);
        applyStimulus(1'b0, '0, 24'd0, 1'b0, 24'd0, 1'b1);
    endtask

    task automatic doFill(input logic [23:0] color, input bit with_commit);
        checkOutput("fill_busy_first", 2, 1, 24'd1);
        checkOutput("fill_busy_last", 2, NPIX, 24'd1);
        checkOutput("fill_wr_ready", 1, 1, 24'd0);
        if (with_commit) begin
            checkOutput("fill_commit_pending", 3, 1, 24'd1);
            checkOutput("pend_after_fill", 3, NPIX + 1, 24'd1);
            checkOutput("pend_busy", 2, NPIX + 1, 24'd1);
        end else begin
            checkOutput("fill_done_idle", 2, NPIX + 1, 24'd0);
        end
        applyStimulus(1'b0, '0, 24'd0, 1'b1, color, with_commit);
        for (int i = 0; i < NPIX; i++) back_img[i] = color;
        tick();
        applyStimulus(1'b0, '0, 24'd0, 1'b1, ~color, 1'b0);
        repeat (NPIX - 1) tick();
    endtask

    task automatic readAddr(input int a);
        ram_rd_addr = AW'(a);
        checkOutput($sformatf("rd_data[%0d]", a), 0, 1, model_read(a));
        tick();
    endtask

    task automatic readFrame();
        for (int a = 0; a < NPIX + 2; a++) readAddr(a);
        readAddr(255);
    endtask

    task automatic endFrame(input bit swap);
        ram_rd_addr = '0;
        checkOutput("frame_done", 4, 1, 24'd1);
        checkOutput("frame_done_pulse", 4, 2, 24'd0);
        checkOutput("rd_data_old_front", 0, 1, model_read(0));
        if (swap) begin
            checkOutput("pending_at_boundary", 3, 0, 24'd1);
            checkOutput("pending_clear", 3, 1, 24'd0);
            checkOutput("copy_busy_first", 2, 1, 24'd1);
            checkOutput("copy_busy_last", 2, NPIX, 24'd1);
            checkOutput("copy_done", 2, NPIX + 1, 24'd0);
            checkOutput("ready_after_copy", 1, NPIX + 1, 24'd1);
            front_img = back_img;
            model_fv  = 1'b1;
        end
        checkOutput("rd_data_new_front", 0, 2, model_read(0));
        repeat (NPIX + 2) tick();
    endtask

    task automatic frameBoundary(input bit swap);
        ram_rd_addr = AW'(1);
        tick();
        endFrame(swap);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) tick();
        checkOutput("reset_wr_ready", 1, 0, 24'd1);
        checkOutput("reset_busy", 2, 0, 24'd0);
        checkOutput("reset_pending", 3, 0, 24'd0);
        checkOutput("reset_frame_done", 4, 0, 24'd0);
        checkOutput("reset_rd_data", 0, 0, 24'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL direct_wr_ready_after_reset got=%b", wr_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL direct_busy_after_reset got=%b", busy);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("no_frame_done_idle", 4, 0, 24'd0);
            tick();
        end
        readFrame();
        endFrame(1'b0);

        $display("[TB] fill and commit together");
        doFill(24'h102030, 1'b1);
        frameBoundary(1'b1);
        ram_rd_addr = AW'(6);
        checkOutput("fill_pattern_const", 0, 1, 24'h0C0804);
        tick();
        readFrame();
        endFrame(1'b0);

        $display("[TB] single red pixel");
        writePixel(0, 24'hFF0000);
        doCommit();
        frameBoundary(1'b1);
        checkOutput("red_const", 0, 1, 24'h00FF00);
        tick();
        readFrame();
        endFrame(1'b0);

        $display("[TB] brightness scaling");
        writePixel(5, 24'hFFFFFF);
        doCommit();
        frameBoundary(1'b1);
        brightness = 8'd127;
        ram_rd_addr = AW'(5);
        checkOutput("bri127_const", 0, 1, 24'hFEFEFE);
        tick();
        brightness = 8'd0;
        readFrame();
        endFrame(1'b0);
        brightness = 8'd255;

        $display("[TB] commit at boundary, mid-frame pend");
        writePixel(2, 24'($urandom));
        ram_rd_addr = AW'(1);
        tick();
        ram_rd_addr = '0;
        commit = 1'b1;
        checkOutput("boundary_commit_frame_done", 4, 1, 24'd1);
        checkOutput("boundary_commit_pending", 3, 1, 24'd1);
        checkOutput("boundary_commit_busy", 2, 2, 24'd1);
        tick();
        commit = 1'b0;
        readAddr(1);
        readAddr(2);
        checkOutput("pend_hold", 3, 0, 24'd1);
        readAddr(3);
        ram_rd_addr = AW'(4);
        checkOutput("rd_data[4]", 0, 1, model_read(4));
        checkOutput("pend_wr_ready", 1, 0, 24'd0);
        applyStimulus(1'b1, AW'(3), 24'($urandom), 1'b0, 24'd0, 1'b0);
        ram_rd_addr = AW'(5);
        checkOutput("rd_data[5]", 0, 1, model_read(5));
        applyStimulus(1'b0, '0, 24'd0, 1'b1, 24'hABCDEF, 1'b1);
        readAddr(6);
        readAddr(7);
        endFrame(1'b1);
        readFrame();
        endFrame(1'b0);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 6; r++) begin
            brightness = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) doFill(24'($urandom), 1'b0);
            for (int w = 0; w < 3; w++) writePixel(int'($urandom_range(0, NPIX + 1)), 24'($urandom));
            doCommit();
            frameBoundary(1'b1);
            readFrame();
            endFrame(1'b0);
        end

        $display("[TB] reset during copy");
        brightness = 8'd255;
        writePixel(0, 24'h123456);
        doCommit();
        ram_rd_addr = AW'(1);
        tick();
        ram_rd_addr = '0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        model_fv = 1'b0;
        checkOutput("async_rst_busy", 2, 0, 24'd0);
        checkOutput("async_rst_pending", 3, 0, 24'd0);
        checkOutput("async_rst_rd_data", 0, 0, 24'd0);
        checkOutput("async_rst_wr_ready", 1, 0, 24'd1);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL direct_async_rst_busy got=%b", busy);
        end
        checks++;
        if (commit_pending !== 1'b0) begin
            failures++;
            $display("[TB] FAIL direct_async_rst_pending got=%b", commit_pending);
        end
        checks++;
        if (ram_rd_data !== 24'd0) begin
            failures++;
            $display("[TB] FAIL direct_async_rst_rd_data got=%h", ram_rd_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        readFrame();
        endFrame(1'b0);
        doFill(24'($urandom), 1'b0);
        writePixel(4, 24'($urandom));
        doCommit();
        frameBoundary(1'b1);
        readFrame();
        endFrame(1'b0);

        repeat (3) tick();
        while (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s never_checked due=%0d", name_q[0], exp_q[0].due);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
